// File: rtl/input_setup.sv
// Captures a 2x2 activation tile from the unified buffer and feeds it into the
// two systolic-array rows with one cycle of diagonal skew (row 1 lags row 0).
module input_setup #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_input,
  input  logic [DATA_W-1:0] in_ub_00,
  input  logic [DATA_W-1:0] in_ub_01,
  input  logic [DATA_W-1:0] in_ub_10,
  input  logic [DATA_W-1:0] in_ub_11,
  input  logic              stall,
  output logic [DATA_W-1:0] row0_data,
  output logic              row0_valid,
  output logic [DATA_W-1:0] row1_data,
  output logic              row1_valid,
  output logic              busy,
  output logic              done,
  output logic              dropped
);

  // state | meaning
  // IDLE  | no transfer, waiting for load_input
  // WAIT  | unified buffer words settling, captured at end of cycle
  // FEED0 | row0=a00
  // FEED1 | row0=a01, row1=a10
  // FEED2 | row1=a11
  // DONE  | one-cycle done pulse, may accept a new load_input
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FEED0,
    S_FEED1,
    S_FEED2,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] tile_00, tile_01, tile_10, tile_11;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tile_00    <= '0;
      tile_01    <= '0;
      tile_10    <= '0;
      tile_11    <= '0;
      row0_data  <= '0;
      row0_valid <= 1'b0;
      row1_data  <= '0;
      row1_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      done    <= 1'b0;
      dropped <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          row0_data  <= '0;
          row0_valid <= 1'b0;
          row1_data  <= '0;
          row1_valid <= 1'b0;
          if (load_input) begin
            state <= S_WAIT;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          // Outputs for FEED0 come straight from the buffer words being captured now.
          dropped    <= load_input;
          tile_00    <= in_ub_00;
          tile_01    <= in_ub_01;
          tile_10    <= in_ub_10;
          tile_11    <= in_ub_11;
          state      <= S_FEED0;
          row0_data  <= in_ub_00;
          row0_valid <= 1'b1;
          row1_data  <= '0;
          row1_valid <= 1'b0;
        end
        S_FEED0: begin
          dropped <= load_input;
          if (!stall) begin
            state      <= S_FEED1;
            row0_data  <= tile_01;
            row0_valid <= 1'b1;
            row1_data  <= tile_10;
            row1_valid <= 1'b1;
          end
        end
        S_FEED1: begin
          dropped <= load_input;
          if (!stall) begin
            state      <= S_FEED2;
            row0_data  <= '0;
            row0_valid <= 1'b0;
            row1_data  <= tile_11;
            row1_valid <= 1'b1;
          end
        end
        S_FEED2: begin
          dropped <= load_input;
          if (!stall) begin
            state      <= S_DONE;
            row0_data  <= '0;
            row0_valid <= 1'b0;
            row1_data  <= '0;
            row1_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          row0_data  <= '0;
          row0_valid <= 1'b0;
          row1_data  <= '0;
          row1_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_setup.sv
// Scoreboard bench for input_setup: stimulus queues expected (cycle, value)
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_input_setup;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_input = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] in_ub_00 = '0, in_ub_01 = '0, in_ub_10 = '0, in_ub_11 = '0;
  logic [31:0] row0_data, row1_data;
  logic        row0_valid, row1_valid, busy, done, dropped;

  input_setup #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .load_input(load_input),
    .in_ub_00(in_ub_00), .in_ub_01(in_ub_01), .in_ub_10(in_ub_10), .in_ub_11(in_ub_11),
    .stall(stall),
    .row0_data(row0_data), .row0_valid(row0_valid),
    .row1_data(row1_data), .row1_valid(row1_valid),
    .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t q_r0[$], q_r1[$], q_done[$], q_drop[$], q_busy[$];

  task automatic exp_r0(input int c, input logic [31:0] v);
    exp_t e; e.cyc = c; e.val = v; q_r0.push_back(e);
  endtask
  task automatic exp_r1(input int c, input logic [31:0] v);
    exp_t e; e.cyc = c; e.val = v; q_r1.push_back(e);
  endtask
  task automatic exp_done(input int c);
    exp_t e; e.cyc = c; e.val = '0; q_done.push_back(e);
  endtask
  task automatic exp_drop(input int c);
    exp_t e; e.cyc = c; e.val = '0; q_drop.push_back(e);
  endtask
  task automatic exp_busy(input int c_from, input int c_to);
    exp_t e;
    for (int i = c_from; i <= c_to; i++) begin
      e.cyc = i; e.val = '0; q_busy.push_back(e);
    end
  endtask

  // Unstalled tile loaded in cycle c0.
  task automatic exp_basic(input int c0, input logic [31:0] a, b, c, d);
    exp_r0(c0 + 2, a);
    exp_r0(c0 + 3, b);
    exp_r1(c0 + 3, c);
    exp_r1(c0 + 4, d);
    exp_done(c0 + 5);
    exp_busy(c0 + 1, c0 + 4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input logic [31:0] a, b, c, d);
    in_ub_00 = a; in_ub_01 = b; in_ub_10 = c; in_ub_11 = d;
  endtask

  task automatic drain(input string name);
    repeat (5) tick();
    n_checks++;
    if (q_r0.size() + q_r1.size() + q_done.size() + q_drop.size() + q_busy.size() != 0) begin
      n_fail++;
      $display("FAIL %s leftover: pending r0=%0d r1=%0d done=%0d drop=%0d busy=%0d, required all 0",
               name, q_r0.size(), q_r1.size(), q_done.size(), q_drop.size(), q_busy.size());
    end
    q_r0.delete(); q_r1.delete(); q_done.delete(); q_drop.delete(); q_busy.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (row0_valid) begin
        n_checks++;
        if (q_r0.size() == 0) begin
          n_fail++;
          $display("FAIL row0 unexpected: cycle %0d data %h, required no valid", cyc, row0_data);
        end else begin
          e = q_r0.pop_front();
          if (e.cyc != cyc || e.val != row0_data) begin
            n_fail++;
            $display("FAIL row0: cycle %0d data %h, required cycle %0d data %h", cyc, row0_data, e.cyc, e.val);
          end
        end
      end else begin
        n_checks++;
        if (row0_data != '0) begin
          n_fail++;
          $display("FAIL row0 idle data: cycle %0d data %h, required 0", cyc, row0_data);
        end
      end
      if (row1_valid) begin
        n_checks++;
        if (q_r1.size() == 0) begin
          n_fail++;
          $display("FAIL row1 unexpected: cycle %0d data %h, required no valid", cyc, row1_data);
        end else begin
          e = q_r1.pop_front();
          if (e.cyc != cyc || e.val != row1_data) begin
            n_fail++;
            $display("FAIL row1: cycle %0d data %h, required cycle %0d data %h", cyc, row1_data, e.cyc, e.val);
          end
        end
      end else begin
        n_checks++;
        if (row1_data != '0) begin
          n_fail++;
          $display("FAIL row1 idle data: cycle %0d data %h, required 0", cyc, row1_data);
        end
      end
      if (done) begin
        n_checks++;
        if (q_done.size() == 0) begin
          n_fail++;
          $display("FAIL done unexpected: cycle %0d, required no pulse", cyc);
        end else begin
          e = q_done.pop_front();
          if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL done: cycle %0d, required cycle %0d", cyc, e.cyc);
          end
        end
      end
      if (dropped) begin
        n_checks++;
        if (q_drop.size() == 0) begin
          n_fail++;
          $display("FAIL dropped unexpected: cycle %0d, required no pulse", cyc);
        end else begin
          e = q_drop.pop_front();
          if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL dropped: cycle %0d, required cycle %0d", cyc, e.cyc);
          end
        end
      end
      if (busy) begin
        n_checks++;
        if (q_busy.size() == 0) begin
          n_fail++;
          $display("FAIL busy unexpected: cycle %0d, required 0", cyc);
        end else begin
          e = q_busy.pop_front();
          if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL busy: cycle %0d, required cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  int c0;

  initial begin
    // Reset state
    #12;
    n_checks++;
    if ({row0_data, row0_valid, row1_data, row1_valid, busy, done, dropped} != '0) begin
      n_fail++;
      $display("FAIL reset outputs: r0=%h/%b r1=%h/%b busy=%b done=%b dropped=%b, required all 0",
               row0_data, row0_valid, row1_data, row1_valid, busy, done, dropped);
    end
    tick();
    reset = 1'b1;
    tick();

    // Basic tile
    tick(); c0 = cyc;
    set_tile(32'd11, 32'd12, 32'd21, 32'd22);
    exp_basic(c0, 32'd11, 32'd12, 32'd21, 32'd22);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    drain("basic");

    // Stall in cycles 3-4
    tick(); c0 = cyc;
    exp_r0(c0 + 2, 32'd11);
    for (int i = 3; i <= 5; i++) begin
      exp_r0(c0 + i, 32'd12);
      exp_r1(c0 + i, 32'd21);
    end
    exp_r1(c0 + 6, 32'd22);
    exp_done(c0 + 7);
    exp_busy(c0 + 1, c0 + 6);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    tick();
    tick(); stall = 1'b1;
    tick();
    tick(); stall = 1'b0;
    drain("stall");

    // Back-to-back
    tick(); c0 = cyc;
    exp_basic(c0, 32'd11, 32'd12, 32'd21, 32'd22);
    exp_basic(c0 + 5, 32'd5, 32'd6, 32'd7, 32'd8);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    repeat (4) tick();
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    set_tile(32'd5, 32'd6, 32'd7, 32'd8);
    drain("b2b");

    // Overrun
    tick(); c0 = cyc;
    set_tile(32'd11, 32'd12, 32'd21, 32'd22);
    exp_basic(c0, 32'd11, 32'd12, 32'd21, 32'd22);
    exp_drop(c0 + 3);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    tick(); load_input = 1'b1;
    tick(); load_input = 1'b0;
    drain("overrun");

    // Bit-exact
    tick(); c0 = cyc;
    set_tile(32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF);
    exp_basic(c0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    drain("bitexact");

    // Async reset during FEED1
    tick(); c0 = cyc;
    set_tile(32'd31, 32'd32, 32'd41, 32'd42);
    exp_r0(c0 + 2, 32'd31);
    exp_r0(c0 + 3, 32'd32);
    exp_r1(c0 + 3, 32'd41);
    exp_busy(c0 + 1, c0 + 3);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    tick();
    tick();
    #6 reset = 1'b0;
    #1;
    n_checks++;
    if ({row0_data, row0_valid, row1_data, row1_valid, busy, done, dropped} != '0) begin
      n_fail++;
      $display("FAIL async reset: r0=%h/%b r1=%h/%b busy=%b done=%b dropped=%b, required all 0",
               row0_data, row0_valid, row1_data, row1_valid, busy, done, dropped);
    end
    tick();
    tick(); reset = 1'b1;
    drain("abort");
    tick(); c0 = cyc;
    set_tile(32'd1, 32'd2, 32'd3, 32'd4);
    exp_basic(c0, 32'd1, 32'd2, 32'd3, 32'd4);
    load_input = 1'b1;
    tick(); load_input = 1'b0;
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_setup.md
Name: input_setup

Overview:
- Reader-side partner of the unified buffer on the load path. It captures the 2x2 activation tile that the unified buffer presents on its four output words after a load_input strobe.
- It then feeds the tile into the two rows of the 2x2 systolic array with diagonal skew, so row 1 lags row 0 by one cycle.
- It sits between the unified buffer outputs and the systolic array left-edge inputs. It shares the load_input strobe with the unified buffer.

Parameters:
- DATA_W, 32, width of each activation word; must equal the unified buffer word width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_input  input  1  same strobe driven to the unified buffer; starts a tile transfer.
- in_ub_00  input  DATA_W  unified buffer word at addr (tile element a00).
- in_ub_01  input  DATA_W  word at addr+1 (a01).
- in_ub_10  input  DATA_W  word at addr+2 (a10).
- in_ub_11  input  DATA_W  word at addr+3 (a11).
- stall  input  1  systolic array back-pressure; freezes feeding.
- row0_data  output  DATA_W  activation into array row 0.
- row0_valid  output  1  row0_data valid.
- row1_data  output  DATA_W  activation into array row 1.
- row1_valid  output  1  row1_data valid.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse after the last element has been fed.
- dropped  output  1  one-cycle pulse when load_input arrives while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Internal tile registers 0.
  - A reset mid-transfer aborts the transfer; no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- States are IDLE, WAIT, FEED0, FEED1, FEED2, DONE.
- IDLE or DONE:
  - If load_input=1, go to WAIT.
  - Otherwise go to IDLE.
- WAIT (one cycle):
  - The unified buffer updated its outputs on the edge that sampled load_input, so in_ub_* are valid during WAIT.
  - At the end of WAIT, capture all four words into the tile registers and go to FEED0.
  - stall is ignored in WAIT.
- Output values per state (registered, shown during the state cycle):
  - FEED0: row0 = a00 with valid 1; row1 = 0 with valid 0.
  - FEED1: row0 = a01 with valid 1; row1 = a10 with valid 1.
  - FEED2: row0 = 0 with valid 0; row1 = a11 with valid 1.
  - DONE: both rows 0 with valid 0; done=1.
  - IDLE and WAIT: both rows 0 with valid 0.
- Latency: load_input high in cycle 0 gives WAIT in cycle 1, FEED0 in 2, FEED1 in 3, FEED2 in 4, and done in cycle 5.
- Back-to-back: load_input in the DONE cycle is accepted, giving WAIT in cycle 6.
- stall:
  - When stall=1 in a FEED state, the state, row data and valids hold unchanged. The array re-samples identical values.
  - Feeding advances on the first edge with stall=0.
  - stall in IDLE, WAIT or DONE has no effect.
- load_input while busy (WAIT or any FEED state):
  - The strobe is ignored; the transfer in progress is not disturbed.
  - dropped pulses for one cycle.
  - Multiple ignored strobes give multiple pulses.
- Tile registers hold their values after DONE until the next capture.
- No arithmetic is performed; data passes bit-exact.

Test Plan:
- Basic tile:
  - Stimulus: after reset, in_ub = 11/12/21/22 and a load_input pulse in cycle 0.
  - Required: cycles 2..4 show row0 = 11, 12, then invalid, and row1 = invalid, 21, 22; done=1 only in cycle 5; busy=1 in cycles 1..4.
- Stall:
  - Stimulus: same tile with stall=1 in cycles 3-4.
  - Required: row0=12 and row1=21 (both valid) hold for cycles 3..5; FEED2 (row1=22) appears in cycle 6; done in cycle 7.
- Back-to-back:
  - Stimulus: second load_input in cycle 5 with in_ub = 5/6/7/8 valid from cycle 6.
  - Required: first tile as in the basic case; second tile feeds row0 = 5, 6 and row1 = 7, 8 in cycles 7..9; done in cycles 5 and 10.
- Overrun:
  - Stimulus: load_input pulsed in cycles 0 and 2.
  - Required: dropped=1 in cycle 3 only; feed sequence and done timing are identical to the basic case.
- Async reset:
  - Stimulus: reset asserted mid-cycle during FEED1.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no done pulse; after release, a new load_input completes normally.
- Width/bit-exact:
  - Stimulus: in_ub = 32'hFFFF_FFFF / 32'h8000_0000 / 32'h0000_0001 / 32'h7FFF_FFFF.
  - Required: the same values appear unmodified on the row outputs.
